// File: rtl/m2_chan_pkg.sv
// Shared constants, half-select encoding and log2 clamp helper for the
// M/2 channelizer input path.
package m2_chan_pkg;

  localparam int unsigned LOG2_MIN = 3;
  localparam int unsigned LOG2_MAX = 9;
  localparam int unsigned DELAY_W  = 9;
  localparam int unsigned TUSER_W  = 9;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_sel_e;

  function automatic logic [3:0] clamp_log2(input logic [3:0] val,
                                            input int unsigned lo,
                                            input int unsigned hi);
    if (32'(val) < lo) return 4'(lo);
    if (32'(val) > hi) return 4'(hi);
    return val;
  endfunction

endpackage

// File: rtl/axi_skid_buffer_2.sv
// Generic 2-entry AXI-Stream skid buffer: registered output stage plus one
// skid entry; upstream ready is simply "skid entry empty".
module axi_skid_buffer_2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_sync_reset_n,
  input  logic             i_s_valid,
  input  logic [WIDTH-1:0] i_s_data,
  output logic             o_s_ready,
  output logic             o_m_valid,
  output logic [WIDTH-1:0] o_m_data,
  input  logic             i_m_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_in_fire;
  logic             w_out_free;

  assign w_in_fire  = i_s_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || i_m_ready;

  // A full skid blocks new input, so draining it never collides with an accept.
  always_ff @(posedge i_clk) begin
    if (!i_sync_reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_s_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_s_data;
    end
  end

  assign o_s_ready = !r_skid_valid;
  assign o_m_valid = r_out_valid;
  assign o_m_data  = r_out_data;

endmodule

// File: rtl/axi_m2_commutator.sv
// M/2 commutator: counts samples into half-frames, tags branch index / tlast /
// delay. Optional frame counter port enabled by AXI_M2_COMMUTATOR_FRAME_CNT_EN.
module axi_m2_commutator #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG2_MIN   = m2_chan_pkg::LOG2_MIN,
  parameter int unsigned LOG2_MAX   = m2_chan_pkg::LOG2_MAX
) (
  input  logic                  clk,
  input  logic                  sync_reset_n,
  input  logic [3:0]            fft_size_log2,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [8:0]            m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [8:0]            delay_out
`ifdef AXI_M2_COMMUTATOR_FRAME_CNT_EN
  ,
  output logic [31:0]           frame_cnt
`endif
);

  import m2_chan_pkg::half_sel_e;
  import m2_chan_pkg::HALF_LO;
  import m2_chan_pkg::HALF_HI;
  import m2_chan_pkg::DELAY_W;
  import m2_chan_pkg::TUSER_W;
  import m2_chan_pkg::clamp_log2;

  localparam int unsigned SKID_W = 1 + TUSER_W + DELAY_W + DATA_WIDTH;

  logic [3:0]         r_log2;
  logic [TUSER_W-1:0] r_count;
  half_sel_e          r_half;

  logic [3:0]         w_req_log2;
  logic [DELAY_W-1:0] w_half_m;
  logic [TUSER_W-1:0] w_last_idx;
  logic [TUSER_W-1:0] w_tuser;
  logic [DELAY_W-1:0] w_delay;
  logic               w_wrap;
  logic               w_accept;
  logic               w_s_ready;
  logic [SKID_W-1:0]  w_skid_in;
  logic [SKID_W-1:0]  w_skid_out;

  assign w_req_log2 = clamp_log2(fft_size_log2, LOG2_MIN, LOG2_MAX);
  assign w_half_m   = 9'd1 << (r_log2 - 4'd1);
  assign w_last_idx = w_half_m - 9'd1;
  assign w_wrap     = (r_count == w_last_idx);
  assign w_tuser    = w_last_idx - r_count;
  assign w_delay    = (r_half == HALF_HI) ? w_half_m : '0;
  assign w_accept   = s_axis_tvalid && w_s_ready;

  // New size is only adopted when the second half of a full frame completes.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_count <= '0;
      r_half  <= HALF_LO;
      r_log2  <= w_req_log2;
    end else if (w_accept) begin
      if (w_wrap) begin
        r_count <= '0;
        r_half  <= (r_half == HALF_HI) ? HALF_LO : HALF_HI;
        if (r_half == HALF_HI) r_log2 <= w_req_log2;
      end else begin
        r_count <= r_count + 9'd1;
      end
    end
  end

`ifdef AXI_M2_COMMUTATOR_FRAME_CNT_EN
  logic [31:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_frame_cnt <= '0;
    end else if (w_accept && w_wrap && (r_half == HALF_HI)) begin
      r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign w_skid_in = {w_wrap, w_tuser, w_delay, s_axis_tdata};

  axi_skid_buffer_2 #(
    .WIDTH(SKID_W)
  ) u_skid (
    .i_clk         (clk),
    .i_sync_reset_n(sync_reset_n),
    .i_s_valid     (s_axis_tvalid),
    .i_s_data      (w_skid_in),
    .o_s_ready     (w_s_ready),
    .o_m_valid     (m_axis_tvalid),
    .o_m_data      (w_skid_out),
    .i_m_ready     (m_axis_tready)
  );

  assign s_axis_tready = w_s_ready;
  assign {m_axis_tlast, m_axis_tuser, delay_out, m_axis_tdata} = w_skid_out;

endmodule

// File: tb/tb_axi_m2_commutator.sv
// Scoreboard bench for axi_m2_commutator: driver pushes expected fields on
// accept, monitor pops and compares on each output handshake.
`timescale 1ns/1ps
module tb_axi_m2_commutator;

  logic        clk = 1'b0;
  logic        sync_reset_n;
  logic [3:0]  fft_size_log2;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [8:0]  m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [8:0]  delay_out;
`ifdef AXI_M2_COMMUTATOR_FRAME_CNT_EN
  logic [31:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  axi_m2_commutator #(
    .DATA_WIDTH(32),
    .LOG2_MIN  (3),
    .LOG2_MAX  (9)
  ) dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .fft_size_log2(fft_size_log2),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .delay_out    (delay_out)
`ifdef AXI_M2_COMMUTATOR_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [8:0]  tuser;
    logic        tlast;
    logic [8:0]  delay;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Monitor samples 4ns after each edge, well before the driver's negedge.
  initial begin
    logic        prev_stall;
    logic [31:0] pd;
    logic [8:0]  pu;
    logic [8:0]  pdl;
    logic        pl;
    exp_t        e;
    prev_stall = 1'b0;
    pd = '0; pu = '0; pdl = '0; pl = 1'b0;
    forever begin
      @(posedge clk);
      #4;
      if (!sync_reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!m_axis_tvalid || m_axis_tdata != pd || m_axis_tuser != pu ||
              m_axis_tlast != pl || delay_out != pdl) begin
            errors++;
            $display("FAIL stall_hold got v=%0b d=%0d u=%0d l=%0b dl=%0d required v=1 d=%0d u=%0d l=%0b dl=%0d",
                     m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, delay_out, pd, pu, pl, pdl);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_output got d=%0d u=%0d required no output", m_axis_tdata, m_axis_tuser);
          end else begin
            e = exp_q.pop_front();
            if (m_axis_tdata != e.data || m_axis_tuser != e.tuser ||
                m_axis_tlast != e.tlast || delay_out != e.delay) begin
              errors++;
              $display("FAIL sample got d=%0d u=%0d l=%0b dl=%0d required d=%0d u=%0d l=%0b dl=%0d",
                       m_axis_tdata, m_axis_tuser, m_axis_tlast, delay_out, e.data, e.tuser, e.tlast, e.delay);
            end
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        pd = m_axis_tdata; pu = m_axis_tuser; pl = m_axis_tlast; pdl = delay_out;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] d, input int tu, input bit tl, input int dl, input bit push);
    int   n;
    exp_t e;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    n = 0;
    while (!s_axis_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s_axis_tready) begin
      errors++;
      $display("FAIL accept_timeout got tready=0 required tready=1 data=%0d", d);
    end else if (push) begin
      e.data = d; e.tuser = 9'(tu); e.tlast = tl; e.delay = 9'(dl);
      exp_q.push_back(e);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s got remaining=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tuser !== '0 ||
        m_axis_tlast !== 1'b0 || delay_out !== '0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_%s got v=%0b d=%0d u=%0d l=%0b dl=%0d rdy=%0b required v=0 d=0 u=0 l=0 dl=0 rdy=1",
               name, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, delay_out, s_axis_tready);
    end
  endtask

  task automatic do_reset(input logic [3:0] l, input string name);
    fft_size_log2 = l;
    sync_reset_n  = 1'b0;
    @(negedge clk);
    check_reset_state(name);
    sync_reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tu8 [4];
    int dl8 [8];
    tu8 = '{3, 2, 1, 0};
    dl8 = '{0, 0, 0, 0, 4, 4, 4, 4};
    sync_reset_n  = 1'b0;
    fft_size_log2 = 4'd3;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // M=8 continuous stream, plus one-cycle latency on the first sample
    do_reset(4'd3, "m8");
    send(32'd0, tu8[0], 1'b0, dl8[0], 1'b1);
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL first_latency got tvalid=%0b required 1", m_axis_tvalid);
    end
    for (int i = 1; i < 16; i++)
      send(32'(i), tu8[i % 4], (i % 4) == 3, dl8[i % 8], 1'b1);
    drain("m8");

    // M=32 with random backpressure
    ready_mode = 1;
    do_reset(4'd5, "m32");
    for (int i = 0; i < 1000; i++)
      send(32'(i + 100), 15 - (i % 16), (i % 16) == 15, ((i / 16) % 2) ? 16 : 0, 1'b1);
    drain("m32");
    ready_mode = 0;

    // Size change mid-frame takes effect on the next full frame
    do_reset(4'd3, "resize");
    send(32'd500, 3, 1'b0, 0, 1'b1);
    send(32'd501, 2, 1'b0, 0, 1'b1);
    fft_size_log2 = 4'd4;
    send(32'd502, 1, 1'b0, 0, 1'b1);
    send(32'd503, 0, 1'b1, 0, 1'b1);
    send(32'd504, 3, 1'b0, 4, 1'b1);
    send(32'd505, 2, 1'b0, 4, 1'b1);
    send(32'd506, 1, 1'b0, 4, 1'b1);
    send(32'd507, 0, 1'b1, 4, 1'b1);
    for (int i = 0; i < 16; i++)
      send(32'(i + 508), 7 - (i % 8), (i % 8) == 7, (i < 8) ? 0 : 8, 1'b1);
    drain("resize");

    // Clamp above and below range
    do_reset(4'd15, "clamp_hi");
    for (int i = 0; i < 512; i++)
      send(32'(i + 1000), 255 - (i % 256), (i % 256) == 255, (i < 256) ? 0 : 256, 1'b1);
    drain("clamp_hi");
    do_reset(4'd0, "clamp_lo");
    for (int i = 0; i < 8; i++)
      send(32'(i + 2000), 3 - (i % 4), (i % 4) == 3, (i < 4) ? 0 : 4, 1'b1);
    drain("clamp_lo");

    // Reset mid-frame discards a held sample
    do_reset(4'd4, "midreset_pre");
    for (int i = 0; i < 5; i++)
      send(32'(i + 3000), 7 - i, 1'b0, 0, 1'b1);
    drain("midreset_pre");
    ready_mode = 2;
    repeat (2) @(negedge clk);
    send(32'hDEAD_BEEF, 2, 1'b0, 0, 1'b0);
    sync_reset_n = 1'b0;
    @(negedge clk);
    check_reset_state("midframe");
    sync_reset_n = 1'b1;
    ready_mode   = 0;
    send(32'd3100, 7, 1'b0, 0, 1'b1);
    send(32'd3101, 6, 1'b0, 0, 1'b1);
    drain("midreset_post");

`ifdef AXI_M2_COMMUTATOR_FRAME_CNT_EN
    do_reset(4'd3, "frame_cnt");
    for (int i = 0; i < 40; i++)
      send(32'(i + 4000), 3 - (i % 4), (i % 4) == 3, ((i / 4) % 2) ? 4 : 0, 1'b1);
    drain("frame_cnt");
    checks++;
    if (frame_cnt !== 32'd5) begin
      errors++;
      $display("FAIL frame_cnt got %0d required 5", frame_cnt);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
